// File: rtl/gcn_param_engine_pkg.sv
// Shared state type, width helpers and default sizing for the GCN inference engine.
package gcn_pkg;

    localparam int unsigned DefFeatureRows  = 6;
    localparam int unsigned DefFeatureCols  = 96;
    localparam int unsigned DefWeightCols   = 3;
    localparam int unsigned DefDataWidth    = 5;
    localparam int unsigned DefDotProdWidth = 16;
    localparam int unsigned DefAggWidth     = 20;
    localparam int unsigned DefAddressWidth = 13;
    localparam int unsigned DefWeightBase   = 0;
    localparam int unsigned DefFeatureBase  = 512;
    localparam int unsigned DefMaxEdges     = 6;

    typedef enum logic [2:0] {
        StIdle,
        StReadW,
        StReadF,
        StAgg,
        StArgmax,
        StDone
    } state_e;

    // $clog2 that never yields a zero-width vector
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gcn_param_engine_if.sv
// Bus bundle between the engine, the FM/WM read memory, the COO memory and the result consumer.
// master = host/memory side, slave = engine side.
interface gcn_param_engine_if
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS      = DefFeatureRows,
    parameter int unsigned FEATURE_COLS      = DefFeatureCols,
    parameter int unsigned WEIGHT_COLS       = DefWeightCols,
    parameter int unsigned DATA_WIDTH        = DefDataWidth,
    parameter int unsigned ADDRESS_WIDTH     = DefAddressWidth,
    parameter int unsigned MAX_EDGES         = DefMaxEdges,
    parameter int unsigned EDGE_BW           = clog2_min1(MAX_EDGES),
    parameter int unsigned NODE_BW           = clog2_min1(FEATURE_ROWS),
    parameter int unsigned MAX_ADDRESS_WIDTH = clog2_min1(WEIGHT_COLS)
) ();

    logic                                      start;
    logic [EDGE_BW:0]                          num_edges;
    logic [DATA_WIDTH*FEATURE_COLS-1:0]        data_in;
    logic [2*NODE_BW-1:0]                      coo_in;
    logic [EDGE_BW-1:0]                        coo_address;
    logic [ADDRESS_WIDTH-1:0]                  read_address;
    logic                                      enable_read;
    logic                                      busy;
    logic                                      done;
    logic [MAX_ADDRESS_WIDTH*FEATURE_ROWS-1:0] max_addi_answer;

    modport master (
        output start, num_edges, data_in, coo_in,
        input  coo_address, read_address, enable_read, busy, done, max_addi_answer
    );

    modport slave (
        input  start, num_edges, data_in, coo_in,
        output coo_address, read_address, enable_read, busy, done, max_addi_answer
    );

endinterface

// File: rtl/gcn_param_engine_argmax.sv
// gcn_argmax: combinational argmax over WEIGHT_COLS packed values; ties go to the lowest index.
module gcn_argmax #(
    parameter int unsigned WEIGHT_COLS = 3,
    parameter int unsigned AGG_WIDTH   = 20,
    parameter int unsigned IDX_WIDTH   = 2
) (
    input  logic [WEIGHT_COLS*AGG_WIDTH-1:0] vals,
    output logic [IDX_WIDTH-1:0]             idx
);

    logic [AGG_WIDTH-1:0] best;

    // Strict greater-than keeps the earliest column on ties
    always_comb begin
        best = vals[AGG_WIDTH-1:0];
        idx  = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (vals[c*AGG_WIDTH +: AGG_WIDTH] > best) begin
                best = vals[c*AGG_WIDTH +: AGG_WIDTH];
                idx  = IDX_WIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/gcn_param_engine.sv
// gcn_param_engine: one GCN inference pass (combination, COO aggregation, argmax) per start.
// Optional macro GCN_SELF_LOOP_EN seeds every aggregate with its own product row.
module gcn_param_engine
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS      = DefFeatureRows,
    parameter int unsigned FEATURE_COLS      = DefFeatureCols,
    parameter int unsigned WEIGHT_COLS       = DefWeightCols,
    parameter int unsigned DATA_WIDTH        = DefDataWidth,
    parameter int unsigned DOT_PROD_WIDTH    = DefDotProdWidth,
    parameter int unsigned AGG_WIDTH         = DefAggWidth,
    parameter int unsigned ADDRESS_WIDTH     = DefAddressWidth,
    parameter int unsigned WEIGHT_BASE       = DefWeightBase,
    parameter int unsigned FEATURE_BASE      = DefFeatureBase,
    parameter int unsigned MAX_EDGES         = DefMaxEdges,
    parameter int unsigned EDGE_BW           = clog2_min1(MAX_EDGES),
    parameter int unsigned NODE_BW           = clog2_min1(FEATURE_ROWS),
    parameter int unsigned MAX_ADDRESS_WIDTH = clog2_min1(WEIGHT_COLS)
) (
    input logic               clk,
    input logic               reset,
    gcn_param_engine_if.slave bus
);

    localparam int unsigned CntW = clog2_min1(max_u(max_u(WEIGHT_COLS, FEATURE_ROWS), MAX_EDGES) + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t LastW = cnt_t'(WEIGHT_COLS);
    localparam cnt_t LastF = cnt_t'(FEATURE_ROWS);

    state_e                                    state_q;
    cnt_t                                      cnt_q;
    logic [EDGE_BW:0]                          num_edges_q;
    logic [EDGE_BW:0]                          agg_last;
    logic                                      enable_read_q;
    logic [ADDRESS_WIDTH-1:0]                  read_address_q;
    logic [EDGE_BW-1:0]                        coo_address_q;
    logic                                      busy_q;
    logic                                      done_q;
    logic [MAX_ADDRESS_WIDTH*FEATURE_ROWS-1:0] answer_q;
    logic [MAX_ADDRESS_WIDTH*FEATURE_ROWS-1:0] answer_d;

    logic [DATA_WIDTH*FEATURE_COLS-1:0] weight_q [WEIGHT_COLS];
    logic [DOT_PROD_WIDTH-1:0]          prod_q   [FEATURE_ROWS][WEIGHT_COLS];
    logic [AGG_WIDTH-1:0]               agg_q    [FEATURE_ROWS][WEIGHT_COLS];
    logic [AGG_WIDTH-1:0]               agg_d    [FEATURE_ROWS][WEIGHT_COLS];
    logic [DOT_PROD_WIDTH-1:0]          dot      [WEIGHT_COLS];

    logic [DOT_PROD_WIDTH-1:0] dot_acc;
    logic [2*DATA_WIDTH-1:0]   dot_term;
    logic [NODE_BW-1:0]        src;
    logic [NODE_BW-1:0]        dst;
    logic                      edge_ok;
    logic [DOT_PROD_WIDTH-1:0] prod_src [WEIGHT_COLS];
    logic [DOT_PROD_WIDTH-1:0] prod_dst [WEIGHT_COLS];
    logic                      start_accept;

    assign start_accept = (state_q == StIdle || state_q == StDone) && bus.start;
    // num_edges = 0 still spends one (idle) AGG cycle
    assign agg_last     = (num_edges_q == '0) ? '0 : num_edges_q - 1'b1;

    // Control FSM; every bus output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            num_edges_q    <= '0;
            enable_read_q  <= 1'b0;
            read_address_q <= '0;
            coo_address_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            answer_q       <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q        <= StReadW;
                        cnt_q          <= '0;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        enable_read_q  <= 1'b1;
                        read_address_q <= ADDRESS_WIDTH'(WEIGHT_BASE);
                        num_edges_q    <= (bus.num_edges > (EDGE_BW+1)'(MAX_EDGES)) ?
                                          (EDGE_BW+1)'(MAX_EDGES) : bus.num_edges;
                    end
                end
                StReadW: begin
                    if (cnt_q == LastW) begin
                        state_q        <= StReadF;
                        cnt_q          <= '0;
                        enable_read_q  <= 1'b1;
                        read_address_q <= ADDRESS_WIDTH'(FEATURE_BASE);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (32'(cnt_q) + 32'd1 < WEIGHT_COLS) begin
                            enable_read_q  <= 1'b1;
                            read_address_q <= ADDRESS_WIDTH'(WEIGHT_BASE + 32'(cnt_q) + 32'd1);
                        end else begin
                            enable_read_q <= 1'b0;
                        end
                    end
                end
                StReadF: begin
                    if (cnt_q == LastF) begin
                        state_q       <= StAgg;
                        cnt_q         <= '0;
                        coo_address_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (32'(cnt_q) + 32'd1 < FEATURE_ROWS) begin
                            enable_read_q  <= 1'b1;
                            read_address_q <= ADDRESS_WIDTH'(FEATURE_BASE + 32'(cnt_q) + 32'd1);
                        end else begin
                            enable_read_q <= 1'b0;
                        end
                    end
                end
                StAgg: begin
                    if (cnt_q == cnt_t'(agg_last)) begin
                        state_q       <= StArgmax;
                        coo_address_q <= '0;
                    end else begin
                        cnt_q         <= cnt_q + 1'b1;
                        coo_address_q <= EDGE_BW'(32'(cnt_q) + 32'd1);
                    end
                end
                StArgmax: begin
                    answer_q <= answer_d;
                    state_q  <= StDone;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Unsigned dot products of the incoming feature row against every captured weight column
    always_comb begin
        dot_acc  = '0;
        dot_term = '0;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            dot_acc = '0;
            for (int i = 0; i < FEATURE_COLS; i++) begin
                dot_term = (2*DATA_WIDTH)'(bus.data_in[i*DATA_WIDTH +: DATA_WIDTH]) *
                           (2*DATA_WIDTH)'(weight_q[c][i*DATA_WIDTH +: DATA_WIDTH]);
                dot_acc  = dot_acc + DOT_PROD_WIDTH'(dot_term);
            end
            dot[c] = dot_acc;
        end
    end

    // Next aggregate for the current COO edge; out-of-range nodes drop the edge
    always_comb begin
        src     = bus.coo_in[NODE_BW-1:0];
        dst     = bus.coo_in[2*NODE_BW-1:NODE_BW];
        edge_ok = (state_q == StAgg) && (32'(cnt_q) < 32'(num_edges_q)) &&
                  (32'(src) < FEATURE_ROWS) && (32'(dst) < FEATURE_ROWS);
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            prod_src[c] = '0;
            prod_dst[c] = '0;
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                if (32'(src) == r) prod_src[c] = prod_q[r][c];
                if (32'(dst) == r) prod_dst[c] = prod_q[r][c];
            end
        end
        for (int n = 0; n < FEATURE_ROWS; n++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
`ifdef GCN_SELF_LOOP_EN
                agg_d[n][c] = (cnt_q == '0) ? AGG_WIDTH'(prod_q[n][c]) : agg_q[n][c];
`else
                agg_d[n][c] = agg_q[n][c];
`endif
                if (edge_ok && 32'(dst) == n) begin
                    agg_d[n][c] = agg_d[n][c] + AGG_WIDTH'(prod_src[c]);
                end
                // A self edge has already contributed through the dst term
                if (edge_ok && 32'(src) == n && src != dst) begin
                    agg_d[n][c] = agg_d[n][c] + AGG_WIDTH'(prod_dst[c]);
                end
            end
        end
    end

    // Weight capture, product write-back and aggregate accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < WEIGHT_COLS; c++) weight_q[c] <= '0;
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    prod_q[r][c] <= '0;
                    agg_q[r][c]  <= '0;
                end
            end
        end else begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                if (state_q == StReadW && 32'(cnt_q) == c + 1) weight_q[c] <= bus.data_in;
            end
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    if (state_q == StReadF && 32'(cnt_q) == r + 1) prod_q[r][c] <= dot[c];
                    if (start_accept) begin
                        agg_q[r][c] <= '0;
                    end else if (state_q == StAgg) begin
                        agg_q[r][c] <= agg_d[r][c];
                    end
                end
            end
        end
    end

    for (genvar n = 0; n < FEATURE_ROWS; n++) begin : g_argmax
        logic [WEIGHT_COLS*AGG_WIDTH-1:0] vals;

        // Flatten this node's aggregate row for the argmax unit
        always_comb begin
            for (int c = 0; c < WEIGHT_COLS; c++) vals[c*AGG_WIDTH +: AGG_WIDTH] = agg_q[n][c];
        end

        gcn_argmax #(
            .WEIGHT_COLS (WEIGHT_COLS),
            .AGG_WIDTH   (AGG_WIDTH),
            .IDX_WIDTH   (MAX_ADDRESS_WIDTH)
        ) u_argmax (
            .vals (vals),
            .idx  (answer_d[n*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH])
        );
    end

    assign bus.enable_read     = enable_read_q;
    assign bus.read_address    = read_address_q;
    assign bus.coo_address     = coo_address_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.max_addi_answer = answer_q;

endmodule

// File: doc/gcn_param_engine.md
Name: gcn_param_engine

Overview:
- Parametrised successor to the fixed-size GCN core: one full inference pass per start pulse.
- Combination: feature row × weight matrix, all WEIGHT_COLS dot products per row in parallel.
- Aggregation: undirected COO edge stream with a runtime edge count.
- Argmax per node; sits between the shared FM/WM read memory, the COO memory and the result consumer.

Parameters:
- FEATURE_ROWS, 6, number of graph nodes / feature rows
- FEATURE_COLS, 96, feature vector length (= weight rows)
- WEIGHT_COLS, 3, number of output classes
- DATA_WIDTH, 5, unsigned FM/WM element width
- DOT_PROD_WIDTH, 16, product-memory width; wraps mod 2^DOT_PROD_WIDTH
- AGG_WIDTH, 20, aggregate width; wraps mod 2^AGG_WIDTH
- ADDRESS_WIDTH, 13, read_address width
- WEIGHT_BASE, 0, address of weight column 0
- FEATURE_BASE, 512, address of feature row 0
- MAX_EDGES, 6, COO capacity
- EDGE_BW, $clog2(MAX_EDGES), coo_address width
- NODE_BW, $clog2(FEATURE_ROWS), coo_in element width
- MAX_ADDRESS_WIDTH, $clog2(WEIGHT_COLS), argmax index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  sampled in IDLE or DONE only
- num_edges  in  EDGE_BW+1  edges this run; sampled with start; values >MAX_EDGES clamp to MAX_EDGES
- data_in  in  DATA_WIDTH×FEATURE_COLS  FM/WM vector; valid the cycle after enable_read
- coo_in  in  NODE_BW×2  [0]=source, [1]=destination; combinational from coo_address
- coo_address  out  EDGE_BW  current edge index
- read_address  out  ADDRESS_WIDTH  FM/WM address
- enable_read  out  1  read strobe
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  results valid; held until next start accepted
- max_addi_answer  out  MAX_ADDRESS_WIDTH×FEATURE_ROWS  per-node argmax

Behaviour:
- Reset: every output 0, state IDLE. Product, aggregate and weight registers are cleared. Reset mid-run aborts immediately.
- States: IDLE→READ_W→READ_F→AGG→ARGMAX→DONE. DONE→READ_W when start is high; otherwise stay in DONE.
- start is sampled at cycle 0, and the engine enters READ_W at cycle 1. start is ignored while busy.
- Aggregate registers are cleared on READ_W entry.
- READ_W (WEIGHT_COLS+1 cycles):
  - Issue enable_read with read_address = WEIGHT_BASE+c, c = 0..WEIGHT_COLS-1, one per cycle.
  - Capture column c the following cycle.
  - One drain cycle with enable_read=0 ends the state.
- READ_F (FEATURE_ROWS+1 cycles):
  - Same pipelining with read_address = FEATURE_BASE+r.
  - In the capture cycle, compute all WEIGHT_COLS unsigned dot products of row r and write them to prod[r][*] (truncated to DOT_PROD_WIDTH).
- AGG (max(num_edges,1) cycles; num_edges=0 spends 1 idle cycle):
  - coo_address = e, e = 0..num_edges-1.
  - For edge (s,d): agg[d] += prod[s] and agg[s] += prod[d] in the same cycle.
  - Self edge (s==d) is added exactly once.
  - Edge with s or d ≥ FEATURE_ROWS is ignored.
  - coo_address returns to 0 outside AGG.
- ARGMAX (1 cycle):
  - Per node, the index of the largest agg column is registered into max_addi_answer.
  - Ties resolve to the lowest index.
  - done rises the next cycle.
- Done latency: done is first high at cycle 1 + (WEIGHT_COLS+1) + (FEATURE_ROWS+1) + max(num_edges,1) + 1. Defaults with num_edges=6: cycle 19.
- Back-to-back: start high in DONE drops done and busy rises the next cycle. max_addi_answer holds its old value until the new ARGMAX.

Optional Feature:
- Macro GCN_SELF_LOOP_EN.
- Defined: on AGG entry, agg[n] is initialised to prod[n] (implicit self loop for every node).
- Undefined: agg starts at 0, and only COO edges contribute.
- Timing is identical in both cases.

Decomposition:
- Package gcn_pkg: state enum, width helper functions, default parameter constants.
- Sub-module gcn_argmax: combinational argmax over WEIGHT_COLS AGG_WIDTH values, lowest-index tie-break, instantiated per node.

Test Plan:
- Common data for T2–T5:
  - Weight col c is one-hot (value 1) at element c.
  - Feature row r is one-hot at element r mod 3.
  - Hence prod[r] = 1 in column r mod 3.
- T1: Reset, no start for 10 cycles → all outputs 0, enable_read 0, coo_address 0.
- T2: num_edges=0 → done at cycle 14, answers [0,0,0,0,0,0]. With GCN_SELF_LOOP_EN → [0,1,2,0,1,2].
- T3: num_edges=1, edge (0,1), macro off → done at cycle 14, answers [1,0,0,0,0,0].
- T4: edges (2,2),(0,2) → agg[2]=[1,0,1], agg[0]=[0,0,1] → answer[2]=0 (tie, self edge added once), answer[0]=2.
- T5: Edges (7,1),(1,6) with NODE_BW=3 → both ignored, answers all 0. num_edges=9 → only 6 coo_address values issued.
- T6: Reset mid-AGG → next cycle all outputs 0. Then start with T3 data → correct result. start held high through DONE → done drops for exactly one run, then reasserts with the same answers.
